// File: rtl/shake_pkg.sv
// Shared definitions for the SHAKE256 front end: rate geometry,
// pad10*1 constants and the padder state encoding.
package shake_pkg;

  localparam int         RATE_WIDTH       = 1088;
  localparam int         RATE_BYTES       = RATE_WIDTH / 8;
  localparam logic [7:0] SHAKE_DOMAIN_PAD = 8'h1F;
  localparam logic [7:0] PAD_END          = 8'h80;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    PAD,
    START,
    WAIT_DONE,
    ERR
  } state_t;

endpackage

// File: rtl/shake_padder.sv
// SHAKE256 message padder: packs a byte stream into NUM_BLOCKS rate blocks,
// applies pad10*1 with the domain byte, launches KECCAK and holds the bus
// until KECCAK signals completion. Unsupported lengths raise err.
module shake_padder #(
  parameter int         RATE_WIDTH = shake_pkg::RATE_WIDTH,
  parameter int         NUM_BLOCKS = 2,
  parameter logic [7:0] DOMAIN_PAD = shake_pkg::SHAKE_DOMAIN_PAD
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [7:0]                     in_data,
  input  logic                           in_valid,
  input  logic                           in_last,
  output logic                           in_ready,
  output logic [NUM_BLOCKS*RATE_WIDTH-1:0] padded_input,
  output logic                           start,
  input  logic                           done,
  output logic                           busy,
  output logic                           err
);
  import shake_pkg::*;

  localparam int RATE_BYTES = RATE_WIDTH / 8;
  localparam int TOTAL_W    = NUM_BLOCKS * RATE_WIDTH;
  localparam int LW         = $clog2(RATE_BYTES);
  localparam int BW         = $clog2(NUM_BLOCKS + 1);
  localparam int PW         = $clog2(TOTAL_W);

  localparam logic [LW-1:0] LANE_LAST = LW'(RATE_BYTES - 1);
  localparam logic [BW-1:0] BLK_LAST  = BW'(NUM_BLOCKS - 1);

  state_t               state_q, state_d;
  logic [BW-1:0]        blk_q, blk_adv;
  logic [LW-1:0]        lane_q, lane_adv;
  logic [TOTAL_W-1:0]   padded_q, padded_d;
  logic [PW-1:0]        wr_base;
  logic                 done_q;
  logic                 accept;
  logic                 at_end;
  logic                 too_short;
  logic                 done_rise;

  // Byte position bookkeeping: where the current byte lands and where the next one would.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    blk_adv  = blk_q;
    lane_adv = lane_q + LW'(1);
    if (lane_q == LANE_LAST) begin
      lane_adv = '0;
      blk_adv  = blk_q + BW'(1);
    end
    wr_base   = PW'((NUM_BLOCKS - 1 - int'(blk_q)) * RATE_WIDTH + 8 * int'(lane_q));
    accept    = in_valid && in_ready;
    at_end    = (blk_q == BLK_LAST) && (lane_q == LANE_LAST);
    // Too short means the padding byte would still fall before the final block.
    too_short = in_last && ((int'(blk_adv) + 1) < NUM_BLOCKS);
    done_rise = done && !done_q;
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so all flops update together.
      state_q <= state_d;
    end
  end

  // Next-state decode, including the length check on every accepted byte.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, LOAD: begin
        if (accept) begin
          if (at_end || too_short) state_d = ERR;
          else if (in_last)        state_d = PAD;
          else                     state_d = LOAD;
        end
      end
      PAD:       state_d = START;
      START:     state_d = WAIT_DONE;
      WAIT_DONE: if (done_rise) state_d = IDLE;
      ERR:       state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Output decode: in_ready is combinational from state, held low during reset.
  always_comb begin
    in_ready = reset && ((state_q == IDLE) || (state_q == LOAD));
  end

  // Message buffer next value: clear in IDLE, write bytes while loading, OR in padding once.
  always_comb begin
    padded_d = padded_q;
    unique case (state_q)
      IDLE: begin
        padded_d = '0;
        if (accept) padded_d[wr_base +: 8] = in_data;
      end
      LOAD: begin
        if (accept) padded_d[wr_base +: 8] = in_data;
      end
      PAD: begin
        // Sequential ORs so the coinciding case yields 0x9F.
        padded_d[wr_base +: 8]         = padded_d[wr_base +: 8] | DOMAIN_PAD;
        padded_d[RATE_WIDTH-8 +: 8]    = padded_d[RATE_WIDTH-8 +: 8] | PAD_END;
      end
      default: ;
    endcase
  end

  // Datapath registers: message buffer, byte counters and done edge detector.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: the wide buffer is reset because its value is visible on the port.
      padded_q <= '0;
      blk_q    <= '0;
      lane_q   <= '0;
      done_q   <= 1'b0;
    end else begin
      padded_q <= padded_d;
      done_q   <= done;
      unique case (state_q)
        IDLE, LOAD: begin
          if (accept) begin
            blk_q  <= blk_adv;
            lane_q <= lane_adv;
          end
        end
        PAD, ERR: begin
          blk_q  <= '0;
          lane_q <= '0;
        end
        default: ;
      endcase
    end
  end

  // Registered status outputs, derived from the state being entered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      start <= 1'b0;
      err   <= 1'b0;
      busy  <= 1'b0;
    end else begin
      start <= (state_d == START);
      err   <= (state_d == ERR);
      busy  <= (state_d != IDLE);
    end
  end

  assign padded_input = padded_q;

endmodule

// File: tb/tb_shake_padder.sv
// Directed bench for shake_padder: one instance with a single rate block and
// one with two, checking placement, padding, launch timing, errors, done
// handshake and mid-message reset against hand-computed values.
module tb_shake_padder;

  localparam int RW = 1088;
  localparam int W1 = RW;
  localparam int W2 = 2 * RW;

  logic clk;
  logic reset;

  logic [7:0]    d1_data;
  logic          d1_valid, d1_last, d1_ready, d1_start, d1_done, d1_busy, d1_err;
  logic [W1-1:0] d1_pad;

  logic [7:0]    d2_data;
  logic          d2_valid, d2_last, d2_ready, d2_start, d2_done, d2_busy, d2_err;
  logic [W2-1:0] d2_pad;

  int total;
  int bad;

  shake_padder #(.RATE_WIDTH(RW), .NUM_BLOCKS(1), .DOMAIN_PAD(8'h1F)) u_one (
    .clk(clk), .reset(reset),
    .in_data(d1_data), .in_valid(d1_valid), .in_last(d1_last), .in_ready(d1_ready),
    .padded_input(d1_pad), .start(d1_start), .done(d1_done), .busy(d1_busy), .err(d1_err)
  );

  shake_padder #(.RATE_WIDTH(RW), .NUM_BLOCKS(2), .DOMAIN_PAD(8'h1F)) u_two (
    .clk(clk), .reset(reset),
    .in_data(d2_data), .in_valid(d2_valid), .in_last(d2_last), .in_ready(d2_ready),
    .padded_input(d2_pad), .start(d2_start), .done(d2_done), .busy(d2_busy), .err(d2_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Diagnostic print for wide-bus mismatches: first differing byte only.
  task automatic show_bus(input string name, input logic [W2-1:0] got, input logic [W2-1:0] exp);
    int idx;
    idx = -1;
    for (int i = 0; i < W2 / 8; i++) begin
      if (idx < 0 && got[8*i +: 8] !== exp[8*i +: 8]) idx = i;
    end
    if (idx < 0) idx = 0;
    $display("FAIL %s: byte %0d got %02h expected %02h", name, idx, got[8*idx +: 8], exp[8*idx +: 8]);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push1(input logic [7:0] d, input logic l);
    d1_data = d; d1_valid = 1'b1; d1_last = l;
    step();
    d1_valid = 1'b0; d1_last = 1'b0;
  endtask

  task automatic push2(input logic [7:0] d, input logic l);
    d2_data = d; d2_valid = 1'b1; d2_last = l;
    step();
    d2_valid = 1'b0; d2_last = 1'b0;
  endtask

  task automatic done_pulse1();
    d1_done = 1'b1;
    step();
    d1_done = 1'b0;
  endtask

  task automatic done_pulse2();
    d2_done = 1'b1;
    step();
    d2_done = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    step(); step();
    total++; if (d1_ready !== 1'b0) begin bad++; $display("FAIL rst_ready: got %0b expected 0", d1_ready); end
    total++; if (d1_pad !== '0) begin bad++; show_bus("rst_pad", W2'(d1_pad), '0); end
    total++; if ({d1_start, d1_busy, d1_err} !== 3'b000) begin bad++; $display("FAIL rst_flags: got %03b expected 000", {d1_start, d1_busy, d1_err}); end
    total++; if ({d2_start, d2_busy, d2_err, d2_ready} !== 4'b0000) begin bad++; $display("FAIL rst_flags2: got %04b expected 0000", {d2_start, d2_busy, d2_err, d2_ready}); end
    reset = 1'b1;
    #1;
    total++; if (d1_ready !== 1'b1) begin bad++; $display("FAIL rst_release_ready: got %0b expected 1", d1_ready); end
    step();
  endtask

  task automatic test_short_message();
    logic [W1-1:0] exp;
    exp = '0;
    exp[7:0] = 8'h61; exp[15:8] = 8'h62; exp[23:16] = 8'h63; exp[31:24] = 8'h1F; exp[1087:1080] = 8'h80;
    push1(8'h61, 1'b0);
    push1(8'h62, 1'b0);
    push1(8'h63, 1'b1);
    total++; if (d1_start !== 1'b0) begin bad++; $display("FAIL short_pad_cycle_start: got %0b expected 0", d1_start); end
    total++; if (d1_ready !== 1'b0) begin bad++; $display("FAIL short_pad_cycle_ready: got %0b expected 0", d1_ready); end
    step();
    total++; if (d1_start !== 1'b1) begin bad++; $display("FAIL short_start: got %0b expected 1", d1_start); end
    total++; if (d1_pad !== exp) begin bad++; show_bus("short_pad", W2'(d1_pad), W2'(exp)); end
    step();
    total++; if ({d1_start, d1_busy} !== 2'b01) begin bad++; $display("FAIL short_wait: start,busy got %02b expected 01", {d1_start, d1_busy}); end
    done_pulse1();
    total++; if ({d1_busy, d1_ready} !== 2'b01) begin bad++; $display("FAIL short_idle: busy,ready got %02b expected 01", {d1_busy, d1_ready}); end
  endtask

  task automatic test_back_to_back();
    logic [W1-1:0] exp;
    exp = '0;
    exp[7:0] = 8'h11; exp[15:8] = 8'h1F; exp[1087:1080] = 8'h80;
    push1(8'h11, 1'b1);
    step();
    total++; if (d1_start !== 1'b1) begin bad++; $display("FAIL b2b_start: got %0b expected 1", d1_start); end
    total++; if (d1_pad !== exp) begin bad++; show_bus("b2b_pad", W2'(d1_pad), W2'(exp)); end
    step();
    done_pulse1();
  endtask

  task automatic test_coincide_pad();
    logic [W1-1:0] exp;
    logic [W1-1:0] snap;
    int cnt;
    int at;
    exp = '0;
    exp[1087:1080] = 8'h9F;
    snap = '0; cnt = 0; at = -1;
    for (int i = 0; i < 134; i++) push1(8'h00, 1'b0);
    push1(8'h00, 1'b1);
    for (int i = 0; i < 6; i++) begin
      if (d1_start) begin cnt++; at = i; snap = d1_pad; end
      step();
    end
    total++; if (cnt !== 1) begin bad++; $display("FAIL coincide_start_count: got %0d expected 1", cnt); end
    total++; if (at !== 1) begin bad++; $display("FAIL coincide_start_cycle: got %0d expected 1", at); end
    total++; if (snap !== exp) begin bad++; show_bus("coincide_pad", W2'(snap), W2'(exp)); end
    done_pulse1();
  endtask

  task automatic test_two_blocks();
    logic [W2-1:0] exp;
    exp = '0;
    for (int i = 0; i < 136; i++) exp[RW + 8*i +: 8] = 8'hAA;
    exp[7:0] = 8'h1F;
    exp[RW-1 -: 8] = 8'h80;
    for (int i = 0; i < 135; i++) push2(8'hAA, 1'b0);
    push2(8'hAA, 1'b1);
    total++; if (d2_err !== 1'b0) begin bad++; $display("FAIL two_err: got %0b expected 0", d2_err); end
    step();
    total++; if (d2_start !== 1'b1) begin bad++; $display("FAIL two_start: got %0b expected 1", d2_start); end
    total++; if (d2_pad !== exp) begin bad++; show_bus("two_pad", d2_pad, exp); end
    step();
    done_pulse2();
    total++; if ({d2_busy, d2_ready} !== 2'b01) begin bad++; $display("FAIL two_idle: busy,ready got %02b expected 01", {d2_busy, d2_ready}); end
  endtask

  task automatic test_errors();
    for (int i = 0; i < 9; i++) push2(8'h5A, 1'b0);
    push2(8'h5A, 1'b1);
    total++; if ({d2_err, d2_start, d2_ready} !== 3'b100) begin bad++; $display("FAIL short_err: err,start,ready got %03b expected 100", {d2_err, d2_start, d2_ready}); end
    step();
    total++; if ({d2_err, d2_start, d2_busy, d2_ready} !== 4'b0001) begin bad++; $display("FAIL short_err_after: err,start,busy,ready got %04b expected 0001", {d2_err, d2_start, d2_busy, d2_ready}); end
    step();
    total++; if (d2_pad !== '0) begin bad++; show_bus("short_err_clear", d2_pad, '0); end
    total++; if (d2_start !== 1'b0) begin bad++; $display("FAIL short_err_nostart: got %0b expected 0", d2_start); end

    for (int i = 0; i < 135; i++) push1(8'h33, 1'b0);
    total++; if (d1_err !== 1'b0) begin bad++; $display("FAIL long_err_early: got %0b expected 0", d1_err); end
    push1(8'h33, 1'b0);
    total++; if ({d1_err, d1_ready} !== 2'b10) begin bad++; $display("FAIL long_err: err,ready got %02b expected 10", {d1_err, d1_ready}); end
    step();
    total++; if ({d1_err, d1_start, d1_ready} !== 3'b001) begin bad++; $display("FAIL long_err_after: err,start,ready got %03b expected 001", {d1_err, d1_start, d1_ready}); end
    step();
  endtask

  task automatic test_done_hold();
    d1_done = 1'b1;
    step();
    push1(8'h01, 1'b0);
    push1(8'h02, 1'b1);
    step();
    total++; if (d1_start !== 1'b1) begin bad++; $display("FAIL hold_start: got %0b expected 1", d1_start); end
    for (int i = 0; i < 4; i++) begin
      step();
      total++; if ({d1_busy, d1_ready} !== 2'b10) begin bad++; $display("FAIL hold_wait: busy,ready got %02b expected 10", {d1_busy, d1_ready}); end
    end
    d1_done = 1'b0;
    step();
    total++; if (d1_busy !== 1'b1) begin bad++; $display("FAIL hold_low: got %0b expected 1", d1_busy); end
    d1_done = 1'b1;
    step();
    total++; if ({d1_busy, d1_ready} !== 2'b01) begin bad++; $display("FAIL hold_rise: busy,ready got %02b expected 01", {d1_busy, d1_ready}); end
    d1_done = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    logic [W1-1:0] exp;
    exp = '0;
    exp[7:0] = 8'h01; exp[15:8] = 8'h02; exp[23:16] = 8'h03; exp[31:24] = 8'h1F; exp[1087:1080] = 8'h80;
    for (int i = 0; i < 50; i++) push1(8'(i + 1), 1'b0);
    total++; if (d1_busy !== 1'b1) begin bad++; $display("FAIL mid_busy: got %0b expected 1", d1_busy); end
    reset = 1'b0;
    #1;
    total++; if (d1_ready !== 1'b0) begin bad++; $display("FAIL mid_rst_ready: got %0b expected 0", d1_ready); end
    total++; if (d1_pad !== '0) begin bad++; show_bus("mid_rst_pad", W2'(d1_pad), '0); end
    total++; if ({d1_start, d1_busy, d1_err} !== 3'b000) begin bad++; $display("FAIL mid_rst_flags: got %03b expected 000", {d1_start, d1_busy, d1_err}); end
    step();
    reset = 1'b1;
    step();
    push1(8'h01, 1'b0);
    push1(8'h02, 1'b0);
    push1(8'h03, 1'b1);
    step();
    total++; if (d1_start !== 1'b1) begin bad++; $display("FAIL mid_fresh_start: got %0b expected 1", d1_start); end
    total++; if (d1_pad !== exp) begin bad++; show_bus("mid_fresh_pad", W2'(d1_pad), W2'(exp)); end
    step();
    done_pulse1();
  endtask

  initial begin
    total = 0; bad = 0;
    reset = 1'b0;
    d1_data = '0; d1_valid = 1'b0; d1_last = 1'b0; d1_done = 1'b0;
    d2_data = '0; d2_valid = 1'b0; d2_last = 1'b0; d2_done = 1'b0;
    test_reset();
    test_short_message();
    test_back_to_back();
    test_coincide_pad();
    test_two_blocks();
    test_errors();
    test_done_hold();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
